// File: rtl/incr_stream.sv
// incr_stream: pipelined WIDTH-bit incrementer on a valid/ready stream.
// Each accepted beat computes in_data + zero-extended in_step once at
// capture, then travels through STAGES collapsing register slots.
// Results leave in strict FIFO order with a carry flag.
// A saturating counter tallies output beats whose carry was set.
module incr_stream #(
    parameter int WIDTH    = 40,
    parameter int STEP_W   = 8,
    parameter int STAGES   = 2,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [STEP_W-1:0] in_step,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_carry,
    input  logic              ovf_clr,
    output logic [CNT_W-1:0]  ovf_count,
    output logic              busy
);

    // Elaboration-time guards on the parameter ranges the datapath assumes.
    if (WIDTH < 2 || WIDTH > 128) begin : g_bad_width
        $error("incr_stream: WIDTH must be in 2..128");
    end
    if (STEP_W < 1 || STEP_W > WIDTH) begin : g_bad_step_w
        $error("incr_stream: STEP_W must be in 1..WIDTH");
    end
    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("incr_stream: STAGES must be in 1..8");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("incr_stream: CNT_W must be at least 1");
    end

    // (WIDTH+1)-bit sum of the operand and the zero-extended step.
    function automatic logic [WIDTH:0] add_step(input logic [WIDTH-1:0]  a,
                                                input logic [STEP_W-1:0] s);
        return {1'b0, a} + {{(WIDTH + 1 - STEP_W){1'b0}}, s};
    endfunction

    // Wrap keeps the low WIDTH bits; saturate clamps to all-ones on carry.
    function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH:0] sum);
        if (SATURATE != 0 && sum[WIDTH]) begin
            return {WIDTH{1'b1}};
        end
        return sum[WIDTH-1:0];
    endfunction

    // Slot state: slot 0 is the entry slot, slot STAGES-1 drives the output.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [STAGES-1:0] carry_q, carry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // load[k]: slot k may take a new beat this cycle. load[STAGES] is the sink.
    logic [STAGES:0]   load;
    logic [WIDTH:0]    in_sum;
    logic [WIDTH-1:0]  in_result;
    logic              in_fire;
    logic              out_fire;

    // Entry arithmetic, evaluated only for beats that actually transfer.
    always_comb begin
        in_sum    = add_step(in_data, in_step);
        in_result = sat_result(in_sum);
    end

    // Ready chain: a slot can load when empty or when its own beat moves on,
    // which makes the chain an OR of empty flags back from out_ready.
    always_comb begin
        logic [STAGES:0] ld;
        ld         = '0;
        ld[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = !vld_q[k] || ld[k + 1];
        end
        load = ld;
    end

    assign in_ready = reset_l && load[0];
    assign in_fire  = in_valid && in_ready;
    assign out_fire = vld_q[STAGES-1] && out_ready;

    // Slot next-state: loading slots copy their upstream neighbour (or the
    // input); payload only moves with a valid beat so idle inputs never leak.
    always_comb begin
        vld_d   = vld_q;
        data_d  = data_q;
        carry_d = carry_q;

        if (load[0]) begin
            vld_d[0] = in_fire;
            if (in_fire) begin
                data_d[0]  = in_result;
                carry_d[0] = in_sum[WIDTH];
            end
        end

        for (int k = 1; k < STAGES; k++) begin
            if (load[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    data_d[k]  = data_q[k-1];
                    carry_d[k] = carry_q[k-1];
                end
            end
        end
    end

    // Overflow counter: clear wins over a same-cycle carry transfer.
    always_comb begin
        cnt_d = cnt_q;
        if (ovf_clr) begin
            cnt_d = '0;
        end else if (out_fire && carry_q[STAGES-1] && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset empties the pipe and drops in-flight beats.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            vld_q   <= '0;
            data_q  <= '{default: '0};
            carry_q <= '0;
            cnt_q   <= '0;
        end else begin
            vld_q   <= vld_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_data  = out_valid ? data_q[STAGES-1] : '0;
    assign out_carry = out_valid ? carry_q[STAGES-1] : 1'b0;
    assign ovf_count = cnt_q;
    assign busy      = |vld_q;

endmodule

// File: tb/tb_incr_stream.sv
// Bench for incr_stream: a wrap-mode and a saturate-mode instance share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_incr_stream;

    localparam int W = 40;
    localparam int SW = 8;
    localparam int S = 2;
    localparam longint unsigned MAXV = 64'h00FF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset_l;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic [SW-1:0] in_step;
    logic          out_ready;
    logic          ovf_clr;

    logic          in_ready_w, out_valid_w, out_carry_w, busy_w;
    logic [W-1:0]  out_data_w;
    logic [1:0]    ovf_count_w;
    logic          in_ready_s, out_valid_s, out_carry_s, busy_s;
    logic [W-1:0]  out_data_s;
    logic [15:0]   ovf_count_s;

    always #5 clk = ~clk;

    incr_stream #(.WIDTH(W), .STEP_W(SW), .STAGES(S), .SATURATE(0), .CNT_W(2)) dut_w (
        .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_data(in_data), .in_step(in_step), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_data(out_data_w), .out_carry(out_carry_w),
        .ovf_clr(ovf_clr), .ovf_count(ovf_count_w), .busy(busy_w)
    );

    incr_stream #(.WIDTH(W), .STEP_W(SW), .STAGES(S), .SATURATE(1), .CNT_W(16)) dut_s (
        .clk(clk), .reset_l(reset_l), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_step(in_step), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_carry(out_carry_s),
        .ovf_clr(ovf_clr), .ovf_count(ovf_count_s), .busy(busy_s)
    );

    typedef struct {
        logic [W-1:0] dw;
        logic [W-1:0] ds;
        logic         c;
        int           acc;
    } beat_t;

    beat_t q[$];
    int    edge_n = 0;
    int    cnt_w = 0;
    int    cnt_s = 0;
    int    checks = 0;
    int    failures = 0;
    logic  last_in_fire = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check all outputs mid-cycle, then advance the model on the edge.
    task automatic step();
        logic exp_ovalid, exp_ready, in_fire, out_fire;
        longint unsigned sum;
        beat_t b;
        @(negedge clk);
        exp_ovalid = (q.size() > 0) && (edge_n - q[0].acc >= S - 1);
        exp_ready  = reset_l && ((q.size() < S) || out_ready);
        chk("in_ready_w",  64'(in_ready_w),  64'(exp_ready));
        chk("in_ready_s",  64'(in_ready_s),  64'(exp_ready));
        chk("out_valid_w", 64'(out_valid_w), 64'(exp_ovalid));
        chk("out_valid_s", 64'(out_valid_s), 64'(exp_ovalid));
        chk("out_data_w",  64'(out_data_w),  exp_ovalid ? 64'(q[0].dw) : 64'd0);
        chk("out_data_s",  64'(out_data_s),  exp_ovalid ? 64'(q[0].ds) : 64'd0);
        chk("out_carry_w", 64'(out_carry_w), exp_ovalid ? 64'(q[0].c) : 64'd0);
        chk("out_carry_s", 64'(out_carry_s), exp_ovalid ? 64'(q[0].c) : 64'd0);
        chk("busy_w",      64'(busy_w),      64'(q.size() > 0));
        chk("busy_s",      64'(busy_s),      64'(q.size() > 0));
        chk("ovf_count_w", 64'(ovf_count_w), 64'(cnt_w));
        chk("ovf_count_s", 64'(ovf_count_s), 64'(cnt_s));
        in_fire  = in_valid && exp_ready;
        out_fire = exp_ovalid && out_ready;
        @(posedge clk);
        edge_n++;
        last_in_fire = 1'b0;
        if (!reset_l) begin
            q.delete();
            cnt_w = 0;
            cnt_s = 0;
        end else begin
            if (out_fire) begin
                b = q.pop_front();
                if (ovf_clr) begin
                    cnt_w = 0;
                    cnt_s = 0;
                end else if (b.c) begin
                    if (cnt_w < 3) cnt_w++;
                    if (cnt_s < 65535) cnt_s++;
                end
            end else if (ovf_clr) begin
                cnt_w = 0;
                cnt_s = 0;
            end
            if (in_fire) begin
                sum   = longint'(in_data) + longint'(in_step);
                b.c   = sum > MAXV;
                b.dw  = b.c ? W'(sum - MAXV - 1) : W'(sum);
                b.ds  = b.c ? W'(MAXV) : W'(sum);
                b.acc = edge_n;
                q.push_back(b);
                last_in_fire = 1'b1;
            end
        end
        #1;
    endtask

    // Offer one beat and hold it until it is accepted (bounded).
    task automatic send(input logic [W-1:0] d, input logic [SW-1:0] s);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_step  = s;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_in_fire && n < 50);
        if (!last_in_fire) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [63:0] r;
        reset_l   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 40'h12_3456_789A;
        in_step   = 8'h01;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;

        // Reset held three cycles with in_valid asserted.
        for (int i = 0; i < 3; i++) step();
        chk("reset_busy", 64'(busy_w), 64'd0);

        // Wrap / saturate on all-ones + 1, then a plain beat.
        reset_l  = 1'b1;
        in_valid = 1'b1;
        in_data  = 40'hFF_FFFF_FFFF;
        in_step  = 8'h01;
        step();
        chk("wrap_lat_early", 64'(out_valid_w), 64'd0);
        in_data = 40'd5;
        in_step = 8'd3;
        step();
        chk("wrap_data", 64'(out_data_w), 64'd0);
        chk("wrap_carry", 64'(out_carry_w), 64'd1);
        chk("wrap_sat_data", 64'(out_data_s), 64'hFF_FFFF_FFFF);
        in_valid = 1'b0;
        step();
        chk("wrap_next", 64'(out_data_w), 64'd8);
        chk("wrap_next_carry", 64'(out_carry_w), 64'd0);
        chk("wrap_ovf", 64'(ovf_count_w), 64'd1);
        idle(2);

        // Saturate case with a large step.
        in_valid = 1'b1;
        in_data  = 40'hFF_FFFF_FFF0;
        in_step  = 8'h20;
        step();
        in_data = 40'd2;
        in_step = 8'd2;
        step();
        chk("sat_data", 64'(out_data_s), 64'hFF_FFFF_FFFF);
        chk("sat_wrap_data", 64'(out_data_w), 64'h10);
        in_valid = 1'b0;
        step();
        chk("sat_small", 64'(out_data_s), 64'd4);
        idle(2);

        // Backpressure: fill with out_ready low, then drain.
        out_ready = 1'b0;
        begin
            int nxt;
            nxt = 1;
            in_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                in_data = W'(nxt);
                in_step = 8'd1;
                step();
                if (last_in_fire) nxt++;
            end
            chk("bp_accepts", 64'(nxt - 1), 64'd2);
            chk("bp_in_ready", 64'(in_ready_w), 64'd0);
            chk("bp_hold", 64'(out_data_w), 64'd2);
            out_ready = 1'b1;
            while (nxt <= 5) begin
                in_data = W'(nxt);
                step();
                if (last_in_fire) nxt++;
                if (edge_n > 200) begin
                    chk("bp_timeout", 64'd0, 64'd1);
                    nxt = 6;
                end
            end
        end
        idle(4);

        // Counter saturation at CNT_W=2, then clear racing a carry transfer.
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        for (int i = 0; i < 5; i++) send(40'hFF_FFFF_FFFF, 8'd1);
        idle(3);
        chk("cnt_sat", 64'(ovf_count_w), 64'd3);
        send(40'hFF_FFFF_FFFE, 8'd5);
        chk("cnt_pre_clr_valid", 64'(out_valid_w), 64'd0);
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("cnt_clr_w", 64'(ovf_count_w), 64'd0);
        chk("cnt_clr_s", 64'(ovf_count_s), 64'd0);
        idle(2);

        // Mid-flight reset discards two stalled beats.
        out_ready = 1'b0;
        send(40'd100, 8'd0);
        send(40'd200, 8'd0);
        reset_l  = 1'b0;
        in_valid = 1'b1;
        in_data  = 40'd300;
        step();
        chk("mid_rst_valid", 64'(out_valid_w), 64'd0);
        chk("mid_rst_busy", 64'(busy_w), 64'd0);
        reset_l   = 1'b1;
        out_ready = 1'b1;
        in_data   = 40'd7;
        in_step   = 8'd1;
        step();
        in_valid = 1'b0;
        step();
        chk("mid_rst_next", 64'(out_data_w), 64'd8);
        idle(2);

        // Randomized traffic with X on idle data.
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            r = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) r[39:12] = '1;
            in_data   = in_valid ? r[39:0] : 'x;
            in_step   = r[47:40];
            out_ready = ($urandom_range(0, 9) < 7);
            ovf_clr   = ($urandom_range(0, 31) == 0);
            reset_l   = ($urandom_range(0, 99) != 0);
            step();
        end
        reset_l  = 1'b1;
        ovf_clr  = 1'b0;
        out_ready = 1'b1;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/incr_stream.md
Name: incr_stream

Overview:
- Parametrised, pipelined successor to the top-level combinational incrementers.
- Takes a WIDTH-bit operand and a STEP_W-bit step over a valid/ready stream and returns operand+step after STAGES register stages.
- Selectable wrap or saturate mode, a per-beat carry flag and a saturating overflow event counter.
- Sits between a stimulus source and a sink in the example design; it is traced like every other block there.

Parameters:
- WIDTH, 40: operand/result width in bits, legal range 2..128.
- STEP_W, 8: step width in bits, must be <= WIDTH; the step is zero-extended.
- STAGES, 2: pipeline depth in registers, legal range 1..8.
- SATURATE, 0: 0 = wrap modulo 2^WIDTH; 1 = clamp the result to all-ones on carry.
- CNT_W, 16: width of the overflow counter.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- reset_l  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  WIDTH  operand.
- in_step  in  STEP_W  increment amount.
- out_valid  out  1  result beat valid.
- out_ready  in  1  sink accepts the result.
- out_data  out  WIDTH  result.
- out_carry  out  1  carry-out of the addition for this beat.
- ovf_clr  in  1  clears ovf_count.
- ovf_count  out  CNT_W  number of accepted output beats with carry=1, saturating.
- busy  out  1  at least one stage holds a valid beat.

Behaviour:
- Input transfer: occurs when in_valid && in_ready on a rising edge. Output transfer: occurs when out_valid && out_ready on a rising edge.
- Arithmetic is performed at input capture and is (WIDTH+1)-bit: sum = {1'b0,in_data} + zero_ext(in_step). carry = sum[WIDTH].
  - SATURATE=0: result = sum[WIDTH-1:0].
  - SATURATE=1 and carry=1: result = all-ones.
  - Carry is reported in both modes.
- Pipeline: STAGES slots, each holding a valid bit, data and carry.
  - Slot k loads from slot k-1 (slot 0 loads from the input) when slot k is empty or slot k itself advances this cycle.
  - Slot STAGES-1 advances on an output transfer.
  - Bubbles collapse, so any empty slot fills regardless of downstream stall.
- in_ready = reset_l && (slot 0 empty || slot 0 advances this cycle). It is combinational from out_ready through the slot-valid chain; there is no combinational path from in_valid to in_ready.
- Latency: with out_ready held high, a beat accepted at edge N is presented on out_valid after edge N+STAGES-1 and transfers at edge N+STAGES.
- Throughput: 1 beat per cycle when out_ready is held high.
- Capacity: exactly STAGES beats. With out_ready low, in_ready falls once all slots are valid.
- Ordering: strict FIFO, no reordering, no dropping, no duplication.
- out_valid = valid bit of slot STAGES-1. out_data and out_carry are driven 0 whenever out_valid=0. Data is held stable while out_valid && !out_ready.
- busy = OR of all slot valid bits.
- ovf_count, evaluated each edge:
  - ovf_clr=1: count becomes 0. Clear has priority over a simultaneous carry transfer; that event is lost.
  - Otherwise, an output transfer with carry=1 increments the count, unless it is already all-ones, in which case it holds.
- Reset (reset_l=0 at an edge): all slot valid bits, stored data, carry and ovf_count are set to 0.
  - in_ready is 0 in any cycle where reset_l=0.
  - Reset mid-operation discards in-flight beats without emitting them.
  - The first input transfer is possible at the first edge with reset_l=1.
- Values that never transfer have no side effects: an X on in_data while in_valid=0 must not propagate to any output.

Test Plan:
- Reset: hold reset_l=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=0, ovf_count=0, busy=0 throughout.
- Wrap (SATURATE=0, WIDTH=40, STAGES=2): send in_data=40'hFF_FFFF_FFFF, step=1 at edge N -> out_data=0, out_carry=1 valid after edge N+1; then data=5, step=3 -> 8, carry=0; ovf_count=1.
- Saturate (SATURATE=1): send in_data=40'hFF_FFFF_FFF0, step=8'h20 -> out_data=40'hFF_FFFF_FFFF, carry=1; send data=2, step=2 -> out_data=4, carry=0.
- Backpressure: out_ready=0, offer beats 1..5 with step=1 -> in_ready falls after 2 accepts and out_data holds 2; raise out_ready -> outputs 2,3,4,5,6 in order, no gaps once streaming.
- Counter: CNT_W=2, send 5 carry beats -> ovf_count=3 and stays; pulse ovf_clr in the same cycle as a carry transfer -> ovf_count=0.
- Mid-flight reset: 2 beats in flight, out_ready=0, assert reset_l=0 for 1 cycle -> out_valid=0 and busy=0 after that edge; the next beat emerges with correct latency and the discarded beats never appear.
